// File: rtl/mips_regfile_rd.sv
// mips_regfile_rd: 32-entry MIPS register file with one write port and a registered dual read port
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   we, waddr, wdata   write request; writes to index 0 are discarded
//   re, raddr_a/_b     read request, sampled on the rising edge
//   rdata_a/_b, rvalid registered operands, valid for the cycle after a request
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to a colliding read.
// Without it, a colliding read returns the pre-write contents.
module mips_regfile_rd #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [4:0]       raddr_a,
  input  logic [4:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid
);
  logic [WIDTH-1:0] regs [32];
  logic [31:0]      load;
  logic [WIDTH-1:0] val_a, val_b;
  // one-hot load enables; bit 0 masked so $zero never loads
  always_comb load = we ? (32'd1 << waddr) & 32'hFFFF_FFFE : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs <= '{default: '0};
    else for (int k = 1; k < 32; k++) if (load[k]) regs[k] <= wdata;
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    val_a = (raddr_a == 5'd0) ? '0 : (we && waddr == raddr_a) ? wdata : regs[raddr_a];
    val_b = (raddr_b == 5'd0) ? '0 : (we && waddr == raddr_b) ? wdata : regs[raddr_b];
  end
`else
  // regs[0] is never loaded, so index 0 reads as zero without a special case
  always_comb begin
    val_a = regs[raddr_a];
    val_b = regs[raddr_b];
  end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
      rvalid  <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        rdata_a <= val_a;
        rdata_b <= val_b;
      end
    end
endmodule

// File: tb/tb_mips_regfile_rd.sv
// tb_mips_regfile_rd: table-driven checks of the register file read/write behaviour
module tb_mips_regfile_rd;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re = 1'b0;
  logic [4:0]  raddr_a = '0;
  logic [4:0]  raddr_b = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        rvalid;
  int          passed = 0;
  int          total = 0;

  mips_regfile_rd #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ev;
  } vec_t;

  vec_t vecs[$];

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] COLL = 32'hAAAA5555;
`else
  localparam logic [31:0] COLL = 32'h0000_0001;
`endif

  function automatic vec_t mk(logic w, logic [4:0] wa, logic [31:0] wd, logic r,
                              logic [4:0] a, logic [4:0] b, logic [31:0] ea,
                              logic [31:0] eb, logic ev);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.re = r; v.ra = a; v.rb = b;
    v.ea = ea; v.eb = eb; v.ev = ev;
    return v;
  endfunction

  function automatic logic [31:0] after_t0(int i);
    return (i == 8) ? 32'hDEADBEEF : 32'h0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(logic w, logic [4:0] wa, logic [31:0] wd, logic r,
                       logic [4:0] a, logic [4:0] b);
    we = w; waddr = wa; wdata = wd; re = r; raddr_a = a; raddr_b = b;
  endtask

  initial begin
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(0, 0, 0, 1, 5'(2*k), 5'(2*k+1), 0, 0, 1));
    vecs.push_back(mk(1, 8, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8, 0, 32'hDEADBEEF, 0, 1));
    vecs.push_back(mk(1, 0, 32'h12345678, 0, 0, 0, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8, 0, 32'hDEADBEEF, 1));
    for (int k = 1; k < 32; k++)
      vecs.push_back(mk(0, 0, 0, 1, 5'(k), 5'(32-k), after_t0(k), after_t0(32-k), 1));
    vecs.push_back(mk(1, 31, 32'h1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 31, 32'hAAAA5555, 1, 31, 8, COLL, 32'hDEADBEEF, 1));
    vecs.push_back(mk(0, 0, 0, 1, 31, 31, 32'hAAAA5555, 32'hAAAA5555, 1));
    vecs.push_back(mk(1, 29, 32'h1D, 0, 0, 0, 32'hAAAA5555, 32'hAAAA5555, 0));
    vecs.push_back(mk(1, 30, 32'h1E, 0, 0, 0, 32'hAAAA5555, 32'hAAAA5555, 0));
    vecs.push_back(mk(1, 31, 32'h1F, 0, 0, 0, 32'hAAAA5555, 32'hAAAA5555, 0));
    vecs.push_back(mk(1, 1, 32'h01, 0, 0, 0, 32'hAAAA5555, 32'hAAAA5555, 0));
    vecs.push_back(mk(0, 0, 0, 1, 29, 1, 32'h1D, 32'h01, 1));
    vecs.push_back(mk(0, 0, 0, 1, 30, 29, 32'h1E, 32'h1D, 1));
    vecs.push_back(mk(0, 0, 0, 1, 31, 30, 32'h1F, 32'h1E, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 31, 32'h01, 32'h1F, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h01, 32'h1F, 0));

    #12;
    chk("reset rdata_a", rdata_a, 0);
    chk("reset rdata_b", rdata_b, 0);
    chk("reset rvalid", 32'(rvalid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].re, vecs[i].ra, vecs[i].rb);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d rdata_a", i), rdata_a, vecs[i].ea);
      chk($sformatf("vec%0d rdata_b", i), rdata_b, vecs[i].eb);
      chk($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(vecs[i].ev));
    end

    @(negedge clk);
    drive(1, 16, 32'hFFFFFFFF, 0, 0, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    drive(0, 0, 0, 1, 16, 16);
    @(posedge clk);
    #1;
    chk("r16 rdata_a", rdata_a, 32'hFFFFFFFF);
    chk("r16 rvalid", 32'(rvalid), 1);
    @(negedge clk);
    drive(0, 0, 0, 1, 16, 8);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst rdata_a", rdata_a, 0);
    chk("async rst rdata_b", rdata_b, 0);
    chk("async rst rvalid", 32'(rvalid), 0);
    @(posedge clk);
    #1;
    chk("in rst rvalid", 32'(rvalid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("post rst no pulse", 32'(rvalid), 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 16, 8);
    @(posedge clk);
    #1;
    chk("post rst r16", rdata_a, 0);
    chk("post rst r8", rdata_b, 0);
    chk("post rst rvalid", 32'(rvalid), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
